// File: rtl/ram64_arb_pkg.sv
// Types and widths for the ram64_arb slice; geometry comes from ram64_arb_defs.vh.
package ram64_arb_pkg;
`include "ram64_arb_defs.vh"
  localparam int DATA_W = 16;

  typedef enum logic {
    ST_CLEAR = ST_CLEAR_ENC,
    ST_SERVE = ST_SERVE_ENC
  } state_t;
endpackage

// File: rtl/ram64_arb_if.sv
// Two-requester bus into ram64_arb; master is the requester side, slave the arbiter.
interface ram64_arb_if;
  import ram64_arb_pkg::*;

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );
endinterface

// File: rtl/RAM64.sv
// 64x16 single-port RAM: synchronous write on load, asynchronous read.
// Latency: write lands at the clock edge, read data follows addr combinationally.
// Backpressure: none; one access per cycle.
module RAM64
  import ram64_arb_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              clk,
  output logic [DATA_W-1:0] out
);
  logic [DATA_W-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (load) mem[addr] <= in;
  end

  assign out = mem[addr];
endmodule

// File: rtl/ram64_arb_defs.vh
// State encodings and RAM geometry shared by every ram64_arb source file.
`ifndef RAM64_ARB_DEFS_VH
`define RAM64_ARB_DEFS_VH
localparam logic ST_CLEAR_ENC = 1'b0;
localparam logic ST_SERVE_ENC = 1'b1;
localparam int   RAM_DEPTH    = 64;
localparam int   ADDR_W       = 6;
`endif

// File: rtl/ram64_arb.sv
// Two-port arbiter owning one RAM64; RAM64_ARB_CLEAR_EN adds a post-reset zeroing sweep.
// Latency: combinational grant, read data and rvalid registered one cycle after the grant.
// Backpressure: a losing requester holds its request; all requests wait while busy.
module ram64_arb
  import ram64_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input logic        clk,
  input logic        rst_n,
  ram64_arb_if.slave bus
);
  logic              g0, g1;
  logic              last_gnt;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              serving;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_in, ram_out;
  logic              ram_load;

`ifdef RAM64_ARB_CLEAR_EN
  state_t            state;
  logic [ADDR_W-1:0] clear_cnt;
  logic              clearing;

  assign serving  = (state == ST_SERVE);
  assign clearing = rst_n && (state == ST_CLEAR);
  assign bus.busy = (state == ST_CLEAR);
`else
  assign serving  = 1'b1;
  assign bus.busy = 1'b0;
`endif

  // last_gnt names the port granted most recently; ties go to the other one.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n && serving) begin
      if (FIXED_PRIO != 0) begin
        g0 = bus.req0;
        g1 = bus.req1 & ~bus.req0;
      end else begin
        g0 = bus.req0 & (~bus.req1 | last_gnt);
        g1 = bus.req1 & (~bus.req0 | ~last_gnt);
      end
    end
  end

  always_comb begin
    ram_addr = '0;
    ram_in   = '0;
    ram_load = 1'b0;
    if (g0) begin
      ram_addr = bus.addr0;
      ram_in   = bus.wdata0;
      ram_load = bus.we0;
    end else if (g1) begin
      ram_addr = bus.addr1;
      ram_in   = bus.wdata1;
      ram_load = bus.we1;
    end
`ifdef RAM64_ARB_CLEAR_EN
    if (clearing) begin
      ram_addr = clear_cnt;
      ram_in   = '0;
      ram_load = 1'b1;
    end
`endif
  end

  RAM64 u_ram (
    .in   (ram_in),
    .addr (ram_addr),
    .load (ram_load),
    .clk  (clk),
    .out  (ram_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      last_gnt <= 1'b1;
`ifdef RAM64_ARB_CLEAR_EN
      state     <= ST_CLEAR;
      clear_cnt <= '0;
`endif
    end else begin
      rvalid0 <= g0 & ~bus.we0;
      rvalid1 <= g1 & ~bus.we1;
      if ((g0 & ~bus.we0) | (g1 & ~bus.we1)) rdata <= ram_out;
      if (g0) last_gnt <= 1'b0;
      else if (g1) last_gnt <= 1'b1;
`ifdef RAM64_ARB_CLEAR_EN
      if (state == ST_CLEAR) begin
        clear_cnt <= clear_cnt + 1'b1;
        if (clear_cnt == ADDR_W'(RAM_DEPTH - 1)) state <= ST_SERVE;
      end
`endif
    end
  end

  assign bus.gnt0    = g0;
  assign bus.gnt1    = g1;
  assign bus.rvalid0 = rvalid0;
  assign bus.rvalid1 = rvalid1;
  assign bus.rdata   = rdata;
endmodule

// File: tb/tb_ram64_arb.sv
// Directed bench for ram64_arb: round-robin instance (ba) and fixed-priority instance (bb).
module tb_ram64_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

`ifdef RAM64_ARB_CLEAR_EN
  localparam int SWEEP = 64;
`else
  localparam int SWEEP = 0;
`endif

  ram64_arb_if ba ();
  ram64_arb_if bb ();

  ram64_arb #(.FIXED_PRIO(0)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(ba.slave));
  ram64_arb #(.FIXED_PRIO(1)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bb.slave));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_all();
    ba.req0 = 0; ba.req1 = 0; ba.we0 = 0; ba.we1 = 0;
    ba.addr0 = '0; ba.addr1 = '0; ba.wdata0 = '0; ba.wdata1 = '0;
    bb.req0 = 0; bb.req1 = 0; bb.we0 = 0; bb.we1 = 0;
    bb.addr0 = '0; bb.addr1 = '0; bb.wdata0 = '0; bb.wdata1 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_all();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    @(negedge clk);
    while (ba.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    idle_all();
    ba.req0 = 1; ba.req1 = 1; bb.req0 = 1; bb.req1 = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ba.gnt0, ba.gnt1, bb.gnt0, bb.gnt1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gnt: got %b%b%b%b want 0000", ba.gnt0, ba.gnt1, bb.gnt0, bb.gnt1);
    end
    checks++;
    if ({ba.rvalid0, ba.rvalid1} !== 2'b00 || ba.rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_read: rvalid=%b%b rdata=%h want 00/0000", ba.rvalid0, ba.rvalid1, ba.rdata);
    end
    idle_all();
    @(posedge clk);
    #1 rst_n = 1;
    wait_ready(n);
    checks++;
    if (n !== SWEEP) begin
      errors++;
      $display("FAIL reset_busy_cycles: got %0d want %0d", n, SWEEP);
    end
  endtask

  task automatic test_alternate();
    int k0 = 0;
    int k1 = 0;
    logic e0;
    for (int c = 0; c < 6; c++) begin
      step();
      ba.req0 = 1; ba.we0 = 1; ba.addr0 = 6'(10 + k0); ba.wdata0 = 16'(16'h1000 + k0);
      ba.req1 = 1; ba.we1 = 1; ba.addr1 = 6'(20 + k1); ba.wdata1 = 16'(16'h2000 + k1);
      @(negedge clk);
      e0 = (c % 2 == 0);
      checks++;
      if (ba.gnt0 !== e0 || ba.gnt1 !== ~e0) begin
        errors++;
        $display("FAIL alternate_c%0d: gnt0/gnt1=%b%b want %b%b", c, ba.gnt0, ba.gnt1, e0, ~e0);
      end
      checks++;
      if ({ba.rvalid0, ba.rvalid1} !== 2'b00) begin
        errors++;
        $display("FAIL alternate_rvalid_c%0d: got %b%b want 00", c, ba.rvalid0, ba.rvalid1);
      end
      if (e0) k0++;
      else k1++;
    end
    step();
    ba.req1 = 1; ba.addr1 = 6'd22;
    @(negedge clk);
    checks++;
    if ({ba.gnt0, ba.gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL single_req1: gnt=%b%b want 01", ba.gnt0, ba.gnt1);
    end
    step();
    ba.req0 = 1; ba.addr0 = 6'd11;
    @(negedge clk);
    checks++;
    if (ba.gnt0 !== 1'b1 || ba.rvalid1 !== 1'b1 || ba.rdata !== 16'h2002) begin
      errors++;
      $display("FAIL readback_22: gnt0=%b rvalid1=%b rdata=%h want 1/1/2002", ba.gnt0, ba.rvalid1, ba.rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if ({ba.rvalid0, ba.rvalid1} !== 2'b10 || ba.rdata !== 16'h1001) begin
      errors++;
      $display("FAIL readback_11: rvalid=%b%b rdata=%h want 10/1001", ba.rvalid0, ba.rvalid1, ba.rdata);
    end
  endtask

  task automatic test_write_read();
    step();
    ba.req0 = 1; ba.we0 = 1; ba.addr0 = 6'b110011; ba.wdata0 = 16'habcd;
    @(negedge clk);
    checks++;
    if ({ba.gnt0, ba.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL wr_gnt: gnt=%b%b want 10", ba.gnt0, ba.gnt1);
    end
    step();
    ba.req0 = 1; ba.addr0 = 6'b110011;
    @(negedge clk);
    checks++;
    if (ba.gnt0 !== 1'b1 || ba.rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL rd_gnt: gnt0=%b rvalid0=%b want 1/0", ba.gnt0, ba.rvalid0);
    end
    step();
    @(negedge clk);
    checks++;
    if (ba.rvalid0 !== 1'b1 || ba.rdata !== 16'habcd) begin
      errors++;
      $display("FAIL rd_data: rvalid0=%b rdata=%h want 1/abcd", ba.rvalid0, ba.rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if (ba.rvalid0 !== 1'b0 || ba.rdata !== 16'habcd) begin
      errors++;
      $display("FAIL rd_hold: rvalid0=%b rdata=%h want 0/abcd", ba.rvalid0, ba.rdata);
    end
  endtask

  task automatic test_cross_port();
    step();
    ba.req1 = 1; ba.we1 = 1; ba.addr1 = 6'd5; ba.wdata1 = 16'h1234;
    @(negedge clk);
    checks++;
    if ({ba.gnt0, ba.gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL cross_wr_gnt: gnt=%b%b want 01", ba.gnt0, ba.gnt1);
    end
    step();
    ba.req0 = 1; ba.addr0 = 6'd5;
    @(negedge clk);
    checks++;
    if (ba.gnt0 !== 1'b1 || ba.rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL cross_rd_gnt: gnt0=%b rvalid1=%b want 1/0", ba.gnt0, ba.rvalid1);
    end
    step();
    @(negedge clk);
    checks++;
    if ({ba.rvalid0, ba.rvalid1} !== 2'b10 || ba.rdata !== 16'h1234) begin
      errors++;
      $display("FAIL cross_rd_data: rvalid=%b%b rdata=%h want 10/1234", ba.rvalid0, ba.rvalid1, ba.rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ad [3] = '{6'd51, 6'd5, 6'd10};
    logic [15:0] ex [3] = '{16'habcd, 16'h1234, 16'h1000};
    for (int i = 0; i < 3; i++) begin
      step();
      ba.req0 = 1; ba.addr0 = ad[i];
      @(negedge clk);
      checks++;
      if (ba.gnt0 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_gnt_%0d: gnt0=%b want 1", i, ba.gnt0);
      end
      if (i > 0) begin
        checks++;
        if (ba.rvalid0 !== 1'b1 || ba.rdata !== ex[i-1]) begin
          errors++;
          $display("FAIL b2b_data_%0d: rvalid0=%b rdata=%h want 1/%h", i, ba.rvalid0, ba.rdata, ex[i-1]);
        end
      end
    end
    step();
    @(negedge clk);
    checks++;
    if (ba.rvalid0 !== 1'b1 || ba.rdata !== ex[2]) begin
      errors++;
      $display("FAIL b2b_last: rvalid0=%b rdata=%h want 1/%h", ba.rvalid0, ba.rdata, ex[2]);
    end
  endtask

  task automatic test_cancel();
    step();
    ba.req0 = 1; ba.we0 = 1; ba.addr0 = 6'd5; ba.wdata0 = 16'hbeef;
    ba.req1 = 1; ba.addr1 = 6'd5;
    @(negedge clk);
    checks++;
    if ({ba.gnt0, ba.gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL cancel_tie: gnt=%b%b want 01", ba.gnt0, ba.gnt1);
    end
    step();
    @(negedge clk);
    checks++;
    if (ba.rvalid1 !== 1'b1 || ba.rdata !== 16'h1234 || ba.gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL cancel_rd1: rvalid1=%b rdata=%h gnt0=%b want 1/1234/0", ba.rvalid1, ba.rdata, ba.gnt0);
    end
    step();
    ba.req1 = 1; ba.addr1 = 6'd5;
    @(negedge clk);
    checks++;
    if ({ba.gnt0, ba.gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL cancel_repeat_gnt1: gnt=%b%b want 01", ba.gnt0, ba.gnt1);
    end
    step();
    ba.req0 = 1; ba.addr0 = 6'd51;
    @(negedge clk);
    checks++;
    if (ba.rvalid1 !== 1'b1 || ba.rdata !== 16'h1234 || ba.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL cancel_no_write: rvalid1=%b rdata=%h gnt0=%b want 1/1234/1", ba.rvalid1, ba.rdata, ba.gnt0);
    end
  endtask

  task automatic test_fixed_prio();
    for (int i = 0; i < 4; i++) begin
      step();
      bb.req0 = 1; bb.we0 = 1; bb.addr0 = 6'(30 + i); bb.wdata0 = 16'(16'h3000 + i);
      bb.req1 = 1; bb.we1 = 1; bb.addr1 = 6'd40; bb.wdata1 = 16'h4444;
      @(negedge clk);
      checks++;
      if ({bb.gnt0, bb.gnt1} !== 2'b10) begin
        errors++;
        $display("FAIL fixed_c%0d: gnt=%b%b want 10", i, bb.gnt0, bb.gnt1);
      end
    end
    step();
    bb.req1 = 1; bb.we1 = 1; bb.addr1 = 6'd40; bb.wdata1 = 16'h4444;
    @(negedge clk);
    checks++;
    if ({bb.gnt0, bb.gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL fixed_req1_after_drop: gnt=%b%b want 01", bb.gnt0, bb.gnt1);
    end
    step();
    bb.req0 = 1; bb.addr0 = 6'd40;
    @(negedge clk);
    step();
    bb.req0 = 1; bb.addr0 = 6'd33;
    @(negedge clk);
    checks++;
    if (bb.rvalid0 !== 1'b1 || bb.rdata !== 16'h4444) begin
      errors++;
      $display("FAIL fixed_rd40: rvalid0=%b rdata=%h want 1/4444", bb.rvalid0, bb.rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if (bb.rvalid0 !== 1'b1 || bb.rdata !== 16'h3003) begin
      errors++;
      $display("FAIL fixed_rd33: rvalid0=%b rdata=%h want 1/3003", bb.rvalid0, bb.rdata);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    logic [15:0] exp_d;
    exp_d = (SWEEP != 0) ? 16'h0000 : 16'habcd;
    step();
    ba.req0 = 1; ba.addr0 = 6'd51; ba.req1 = 1; ba.addr1 = 6'd5;
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({ba.gnt0, ba.gnt1} !== 2'b00 || ba.rdata !== 16'h0 || bb.rdata !== 16'h0) begin
      errors++;
      $display("FAIL midrun_reset: gnt=%b%b rdata=%h/%h want 00/0000/0000", ba.gnt0, ba.gnt1, ba.rdata, bb.rdata);
    end
    @(posedge clk);
    #1 rst_n = 1;
    wait_ready(n);
    checks++;
    if (n !== SWEEP || {ba.gnt0, ba.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL midrun_first_tie: busy=%0d gnt=%b%b want %0d/10", n, ba.gnt0, ba.gnt1, SWEEP);
    end
    step();
    @(negedge clk);
    checks++;
    if (ba.rvalid0 !== 1'b1 || ba.rdata !== exp_d) begin
      errors++;
      $display("FAIL midrun_read: rvalid0=%b rdata=%h want 1/%h", ba.rvalid0, ba.rdata, exp_d);
    end
  endtask

`ifdef RAM64_ARB_CLEAR_EN
  task automatic test_clear();
    int n = 0;
    int seen = 0;
    step();
    ba.req0 = 1; ba.we0 = 1; ba.addr0 = 6'd63; ba.wdata0 = 16'hffff;
    @(negedge clk);
    step();
    ba.req0 = 1; ba.addr0 = 6'd63;
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (ba.gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL clear_reset_gnt: gnt0=%b want 0", ba.gnt0);
    end
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    while (ba.busy && n < 200) begin
      if (ba.gnt0 !== 1'b0) seen++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 64 || seen !== 0 || ba.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL clear_sweep: busy=%0d gnt_during=%0d gnt0_after=%b want 64/0/1", n, seen, ba.gnt0);
    end
    step();
    @(negedge clk);
    checks++;
    if (ba.rvalid0 !== 1'b1 || ba.rdata !== 16'h0000) begin
      errors++;
      $display("FAIL clear_rd63: rvalid0=%b rdata=%h want 1/0000", ba.rvalid0, ba.rdata);
    end
    step();
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    repeat (30) @(negedge clk);
    step();
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    wait_ready(n);
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL clear_restart: busy=%0d want 64", n);
    end
  endtask
`endif

  initial begin
    idle_all();
    test_reset();
    test_alternate();
    test_write_read();
    test_cross_port();
    test_back_to_back();
    test_cancel();
    test_fixed_prio();
    test_reset_midrun();
`ifdef RAM64_ARB_CLEAR_EN
    test_clear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram64_arb.md
RAM64_ARB -- requirements
Module: ram64_arb

Interface
REQ-001 SHALL have parameter: FIXED_PRIO, default 0, 0 = round-robin arbitration and 1 = port 0 always wins.
REQ-002 SHALL have port: clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req0/req1  in  1  access request, per requester.
REQ-005 SHALL have ports: we0/we1  in  1  1 = write, 0 = read, per requester.
REQ-006 SHALL have ports: addr0/addr1  in  6  word address, per requester.
REQ-007 SHALL have ports: wdata0/wdata1  in  16  write data, per requester.
REQ-008 SHALL have ports: gnt0/gnt1  out  1  combinational grant; the access commits at the rising edge where gnt is 1.
REQ-009 SHALL have ports: rvalid0/rvalid1  out  1  one-cycle pulse marking rdata valid for that port.
REQ-010 SHALL have port: rdata  out  16  registered read data, shared by both ports.
REQ-011 SHALL have port: busy  out  1  high while the clear sweep runs.

Function
REQ-012 SHALL instantiate one RAM64 (in[15:0], addr[5:0], load, clk, out[15:0]) and be its only driver.
REQ-013 SHALL assert at most one gnt per cycle, and only in state SERVE.
REQ-014 SHALL, when FIXED_PRIO=0 and both ports request, grant the port not granted last; the last_gnt register updates on every grant.
REQ-015 SHALL, when only one port requests, grant it regardless of last_gnt.
REQ-016 SHALL, when FIXED_PRIO=1, grant port 0 whenever req0=1.
REQ-017 SHALL require each requester to hold req/we/addr/wdata stable until its gnt is seen; dropping req before grant cancels the request with no side effect.
REQ-018 SHALL, on a granted write, drive RAM addr/in from the granted port with load=1 for that cycle; the write is visible to a read in the next cycle.
REQ-019 SHALL, on a granted read, drive load=0, capture RAM out into rdata at that edge, and pulse the granted port's rvalid in the next cycle (1-cycle latency).
REQ-020 SHALL hold rdata between reads; rvalid SHALL stay low after writes.
REQ-021 SHALL sustain one transaction per cycle, back-to-back, with no bubble.
REQ-022 SHALL drive RAM load=0 whenever no grant is issued and no clear is in progress.

Reset
REQ-023 SHALL, while rst_n=0, force gnt0=gnt1=0, rvalid0=rvalid1=0, rdata=0, last_gnt=1 (port 0 wins the first tie), and clear_cnt=0.
REQ-024 SHALL, on reset deassertion, enter CLEAR if RAM64_ARB_CLEAR_EN is defined, otherwise SERVE.
REQ-025 SHALL, if reset is asserted mid-sweep, restart the sweep from address 0.
REQ-026 SHALL NOT clear RAM contents on reset, except through the sweep.

Configuration
REQ-027 SHALL, with macro RAM64_ARB_CLEAR_EN defined, implement state CLEAR:
- writes 16'h0000 to addresses 0..63 over 64 cycles, clear_cnt incrementing each cycle
- busy=1 throughout; gnt0/gnt1 held 0 and requests wait
- after the address-63 write, moves to SERVE with busy=0
REQ-028 SHALL, without RAM64_ARB_CLEAR_EN, omit CLEAR and clear_cnt, tie busy to 0, and leave RAM contents unspecified after power-up.

Structure
REQ-029 SHALL put the state encodings (CLEAR=0, SERVE=1), the RAM depth (64), and the address width (6) in shared header ram64_arb_defs.vh.
REQ-030 SHALL use RAM64 as the only sub-module; arbitration and FSM logic SHALL be inline.

Verification
REQ-031 Port 0 writes 16'habcd to addr 6'b110011, then reads it -> gnt0 on both cycles; rvalid0=1 with rdata=16'habcd one cycle after the read grant.
REQ-032 Both ports request continuously for 6 cycles (FIXED_PRIO=0) -> grants alternate 0,1,0,1,0,1.
REQ-033 FIXED_PRIO=1, both ports request for 4 cycles -> gnt0 every cycle, gnt1 never; port 1 is granted in the cycle after req0 drops.
REQ-034 CLEAR_EN defined: write 16'hffff to addr 63, pulse rst_n low, req0 read of addr 63 asserted immediately -> busy=1 for 64 cycles, no gnt0 meanwhile; then grant, rdata=16'h0000.
REQ-035 rst_n driven low during sweep cycle 30 -> sweep restarts; busy stays high 64 more cycles after release.
REQ-036 Port 1 writes 16'h1234 to addr 5 and port 0 reads addr 5 in the next cycle -> rdata=16'h1234 with rvalid0, rvalid1 stays 0.
